// File: rtl/pc_gen.sv
// Program-counter unit for the RV32I fetch stage: holds the PC, runs the
// fetch handshake with instruction memory, takes trap/redirect flushes with
// fixed priority, flags misaligned redirect targets and supports debug halt.
module pc_gen #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned     INC          = 4,
  parameter int unsigned     ALIGN_BITS   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            req_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            halt_req,
  input  logic            resume,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_next,
  output logic            req_valid,
  output logic            halted,
  output logic            misalign_err,
  output logic [XLEN-1:0] misalign_addr
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  // Mask form keeps ALIGN_BITS=0 legal (no zero-width slice).
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);
  localparam logic [XLEN-1:0] INC_W      = XLEN'(INC);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            mis_q, mis_d;
  logic [XLEN-1:0] maddr_q, maddr_d;
  logic            misaligned;
  logic            accept;

  assign misaligned = |(redirect_pc & ALIGN_MASK);
  assign req_valid  = (state_q == RUN) && !stall;
  assign accept     = req_valid && req_ready;

  // Next-state / next-PC decode; flushes beat halt, halt beats sequential advance.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    mis_d   = 1'b0;
    maddr_d = maddr_q;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (trap_valid) begin
          pc_d = trap_pc;
        end else if (redirect_valid && !misaligned) begin
          pc_d = redirect_pc;
        end else if (redirect_valid) begin
          pc_d    = TRAP_VECTOR;
          mis_d   = 1'b1;
          maddr_d = redirect_pc;
        end else if (halt_req) begin
          state_d = HALT;
        end else if (accept) begin
          pc_d = pc_q + INC_W;
        end
      end
      HALT: begin
        if (trap_valid) begin
          pc_d    = trap_pc;
          state_d = RUN;
        end else if (resume) begin
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // State, PC and misalign report registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      mis_q   <= 1'b0;
      maddr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mis_q   <= mis_d;
      maddr_q <= maddr_d;
    end
  end

  assign pc            = pc_q;
  assign pc_next       = pc_d;
  assign halted        = (state_q == HALT);
  assign misalign_err  = mis_q;
  assign misalign_addr = maddr_q;

endmodule
